// File: rtl/axi_read_responder.sv
// AXI4 read-channel slave backed by a preloadable on-chip word memory; one burst at a time.
// Optional burst/beat/error counters are built when AXI_RD_STATS_EN is defined.
module axi_read_responder #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        MEM_DEPTH      = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE       = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    input  logic                          wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]  wr_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     wr_data,
    output logic                          busy,
    output logic [31:0]                   stat_bursts,
    output logic [31:0]                   stat_beats,
    output logic [31:0]                   stat_err_beats
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int LG_B  = $clog2(BYTES);
    localparam int IW    = $clog2(MEM_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic                      err;
        logic                      last;
    } beat_t;

    logic [0:0]                state;
    logic                      arready_q;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]                len_q;
    logic [7:0]                issue_cnt;
    logic                      fixed_q;
    logic                      bad_q;
    logic                      issue_done;
    logic                      rd_valid;
    logic                      rd_err;
    logic                      rd_last;
    logic [AXI_DATA_WIDTH-1:0] rd_q;
    beat_t                     fifo [2];
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [1:0]                count;
    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                      rvalid;
    logic                      pop;
    logic                      issue;
    logic                      beat_err;
    logic                      below_base;
    logic                      wr_ok;
    logic [1:0]                occ_after;
    logic [AXI_ADDR_WIDTH-1:0] offset;
    logic [AXI_ADDR_WIDTH-1:0] word;
    beat_t                     head;

    assign head   = fifo[rd_ptr];
    assign rvalid = (count != 2'd0);
    assign pop    = rvalid && s_axi_rready;

    // A read is issued only if the skid still has room once it lands, counting the read in flight.
    assign occ_after = count + {1'b0, rd_valid} - {1'b0, pop};
    assign issue     = (state == ST_BURST) && !issue_done && (occ_after != 2'd2);

    assign {below_base, offset} = {1'b0, cur_addr} - {1'b0, MEM_BASE};
    assign word     = offset >> LG_B;
    assign beat_err = bad_q || below_base || (word >= AXI_ADDR_WIDTH'(MEM_DEPTH));
    assign wr_ok    = ({1'b0, wr_addr} < (IW + 1)'(MEM_DEPTH));

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid;
    assign s_axi_rdata   = rvalid ? head.data : '0;
    assign s_axi_rresp   = (rvalid && head.err) ? 2'b10 : 2'b00;
    assign s_axi_rlast   = rvalid && head.last;
    assign busy          = (state == ST_BURST);

    // NOTE: the memory array has no reset so it maps onto block RAM and survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        // NOTE: non-blocking updates make a same-edge write and read of one word return the old data.
        if (issue) begin
            rd_q <= mem[word[IW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            arready_q  <= 1'b0;
            cur_addr   <= '0;
            len_q      <= '0;
            issue_cnt  <= '0;
            fixed_q    <= 1'b0;
            bad_q      <= 1'b0;
            issue_done <= 1'b0;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
            rd_last    <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_axi_arvalid && arready_q) begin
                        state      <= ST_BURST;
                        arready_q  <= 1'b0;
                        cur_addr   <= s_axi_araddr;
                        len_q      <= s_axi_arlen;
                        fixed_q    <= (s_axi_arburst == 2'b00);
                        bad_q      <= (s_axi_arsize != 3'(LG_B)) || s_axi_arburst[1];
                        issue_cnt  <= '0;
                        issue_done <= 1'b0;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                default: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + 8'd1;
                        if (issue_cnt == len_q) begin
                            issue_done <= 1'b1;
                        end
                        if (!fixed_q) begin
                            cur_addr <= cur_addr + AXI_ADDR_WIDTH'(BYTES);
                        end
                    end
                    if (pop && head.last) begin
                        state     <= ST_IDLE;
                        arready_q <= 1'b1;
                    end
                end
            endcase

            rd_valid <= issue;
            rd_err   <= beat_err;
            rd_last  <= (issue_cnt == len_q);

            if (rd_valid) begin
                fifo[wr_ptr] <= '{data: (rd_err ? '0 : rd_q), err: rd_err, last: rd_last};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, rd_valid} - {1'b0, pop};
        end
    end

`ifdef AXI_RD_STATS_EN
    logic [31:0] bursts_q;
    logic [31:0] beats_q;
    logic [31:0] err_beats_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bursts_q    <= '0;
            beats_q     <= '0;
            err_beats_q <= '0;
        end else if (pop) begin
            beats_q <= beats_q + 32'd1;
            if (head.last) begin
                bursts_q <= bursts_q + 32'd1;
            end
            if (head.err) begin
                err_beats_q <= err_beats_q + 32'd1;
            end
        end
    end

    assign stat_bursts    = bursts_q;
    assign stat_beats     = beats_q;
    assign stat_err_beats = err_beats_q;
`else
    assign stat_bursts    = '0;
    assign stat_beats     = '0;
    assign stat_err_beats = '0;
`endif

endmodule
